lsu_seq: RTL and testbench

Sequential, parametrised load/store unit between the execute stage and the data memory port. Accepts one load/store per handshake and derives byte lanes from the low address bits. Misaligned accesses are split into two memory beats when enabled. Load data is shifted and sign- or zero-extended per fn3, and one response is returned per request. Supersedes the combinational LSU: XLEN=64 support (LD/LWU/SD), address-aware lanes, and a req/gnt/rvalid memory handshake.

---
 rtl/lsu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_seq.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit with a req/gnt/rvalid data-memory port, one response per request.
// Define MISALIGNED_EN to split word-crossing accesses into two beats; without it they are rejected.
module lsu_seq #(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int OFFW = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [2:0]       fn3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [XLEN-1:0]  load_data,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [LANES-1:0] mem_be,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

`ifdef MISALIGNED_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  localparam logic [OFFW+3:0] XlenBits = (OFFW+4)'(XLEN);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

  state_e           state_q, state_d;
  logic             ready_q;
  logic             err_q;
  logic             isLoad_q;
  logic             we_q;
  logic             split_q;
  logic [2:0]       fn3_q;
  logic [OFFW-1:0]  off_q;
  logic [XLEN-1:0]  addr_q;
  logic [LANES-1:0] be_q;
  logic [LANES-1:0] hiBe_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  hiWdata_q;
  logic [XLEN-1:0]  rdata0_q;
  logic [XLEN-1:0]  rdata1_q;

  logic               accept;
  logic [OFFW-1:0]    reqOff;
  logic [3:0]         reqSize;
  logic               reqCross;
  logic               reqErr;
  logic [2*LANES-1:0] sizeMask;
  logic [2*LANES-1:0] reqMask;
  logic [OFFW+2:0]    loShift;
  logic [OFFW+3:0]    hiShift;
  logic [XLEN-1:0]    beat0Wdata;
  logic [XLEN-1:0]    beat1Wdata;

  assign accept = req_valid && req_ready && (is_load || is_store);
  assign reqOff = addr[OFFW-1:0];
  assign reqSize = 4'd1 << fn3[1:0];
  assign reqCross = (int'(reqOff) + int'(reqSize)) > LANES;
  assign loShift = {reqOff, 3'b000};
  assign hiShift = XlenBits - {1'b0, reqOff, 3'b000};
  assign beat0Wdata = store_data << loShift;
  assign beat1Wdata = store_data >> hiShift;

  // Byte mask spanning two words; the upper half is the second beat's lanes.
  always_comb begin
    sizeMask = '0;
    for (int i = 0; i < 2 * LANES; i++) begin
      sizeMask[i] = (i < int'(reqSize));
    end
    reqMask = sizeMask << reqOff;
  end

  always_comb begin
    reqErr = (is_load && is_store)
          || (fn3 == 3'b111)
          || ((XLEN == 32) && ((fn3 == 3'b011) || (fn3 == 3'b110)))
          || (is_store && fn3[2])
          || (!SplitEn && reqCross);
  end

  logic [XLEN-1:0] rawData;
  logic [XLEN-1:0] extData;
  logic [3:0]      qSize;
  logic            signFill;
  int              dataBits;

  // Merge the two beats so the addressed byte lands at bit 0, then extend.
  always_comb begin
    rawData = (rdata0_q >> {off_q, 3'b000}) | (rdata1_q << (XlenBits - {1'b0, off_q, 3'b000}));
    qSize = 4'd1 << fn3_q[1:0];
    dataBits = 8 * int'(qSize);
    case (fn3_q[1:0])
      2'd0:    signFill = rawData[7];
      2'd1:    signFill = rawData[15];
      2'd2:    signFill = rawData[31];
      default: signFill = rawData[XLEN-1];
    endcase
    signFill = signFill && !fn3_q[2];
    extData = '0;
    for (int i = 0; i < XLEN; i++) begin
      extData[i] = (i < dataBits) ? rawData[i] : signFill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_ready = 1'b0;
    mem_req = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ready_q;
        if (accept) state_d = reqErr ? RESP : REQ0;
      end
      REQ0: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = isLoad_q ? WAIT0 : (split_q ? REQ1 : RESP);
      end
      WAIT0: begin
        if (mem_rvalid) state_d = split_q ? REQ1 : RESP;
      end
      REQ1: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = isLoad_q ? WAIT1 : RESP;
      end
      WAIT1: begin
        if (mem_rvalid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_we = mem_req && we_q;
    mem_be = mem_req ? be_q : '0;
    mem_addr = addr_q;
    mem_wdata = wdata_q;
    resp_err = resp_valid && err_q;
    load_data = (resp_valid && !err_q && isLoad_q) ? extData : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q <= 1'b0;
      isLoad_q <= 1'b0;
      we_q <= 1'b0;
      split_q <= 1'b0;
      fn3_q <= '0;
      off_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      hiBe_q <= '0;
      wdata_q <= '0;
      hiWdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if ((state_q == IDLE) && accept) begin
        err_q <= reqErr;
        isLoad_q <= is_load;
        we_q <= is_store && !is_load && !reqErr;
        split_q <= SplitEn && reqCross && !reqErr;
        fn3_q <= fn3;
        off_q <= reqOff;
        addr_q <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        be_q <= reqMask[LANES-1:0];
        hiBe_q <= reqMask[2*LANES-1:LANES];
        wdata_q <= beat0Wdata;
        hiWdata_q <= beat1Wdata;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if ((state_q == WAIT0) && mem_rvalid) rdata0_q <= mem_rdata;
      if ((state_q == WAIT1) && mem_rvalid) rdata1_q <= mem_rdata;
      // Second beat reuses the request registers so they stay stable until granted.
      if ((state_d == REQ1) && (state_q != REQ1)) begin
        addr_q <= addr_q + XLEN'(LANES);
        be_q <= hiBe_q;
        wdata_q <= hiWdata_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed bench for lsu_seq (XLEN=32) with a byte-level memory model and response scoreboard.
// Honours MISALIGNED_EN to select split-beat or reject expectations for word-crossing accesses.
module tb_lsu_seq;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic        isLoad;
    logic [31:0] data;
    int          respCycle;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  fn3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .fn3(fn3),
    .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;
  int respCount = 0;
  int gntDelayCfg = 0;
  int rvalidDelayCfg = 0;
  logic        lastRespErr = 1'b0;
  logic [31:0] lastRespData = '0;

  logic [7:0] memBytes [0:1023];
  resp_t expQ[$];
  beat_t beatQ[$];
  beat_t beatLog[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] laneMask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (be[j]) m[j*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] readWord(input logic [31:0] a);
    return {memBytes[(a + 3) & 1023], memBytes[(a + 2) & 1023], memBytes[(a + 1) & 1023], memBytes[a & 1023]};
  endfunction

  task automatic writeWord(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) memBytes[(a + k) & 1023] = d[k*8 +: 8];
  endtask

  function automatic beat_t getBeat(input int i);
    beat_t b;
    b = '0;
    if (i < beatLog.size()) b = beatLog[i];
    return b;
  endfunction

  function automatic logic modelErr(input logic ld, input logic st, input logic [2:0] f, input logic [31:0] a);
    int size;
    logic e;
    size = 1 << f[1:0];
    e = (ld && st) || (f == 3'b111) || (f == 3'b011) || (f == 3'b110) || (st && f[2]);
`ifndef MISALIGNED_EN
    if ((a % 4) + size > 4) e = 1'b1;
`endif
    return e;
  endfunction

  // Little-endian gather of the accessed bytes, then sign or zero extension.
  function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [31:0] a);
    longint unsigned v;
    int size;
    size = 1 << f[1:0];
    v = 0;
    for (int k = 0; k < size; k++) v = v | (longint'(memBytes[(a + k) & 1023]) << (8 * k));
    if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 1);
    return v[31:0];
  endfunction

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] sd);
    int guard;
    resp_t e;
    beat_t cur;
    beat_t bq[$];
    logic have;
    logic [31:0] ba;
    logic [1:0] lane;
    int size;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL req_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    req_valid = 1'b1;
    is_load = ld;
    is_store = st;
    fn3 = f;
    addr = a;
    store_data = sd;
    if (ld || st) begin
      e.err = modelErr(ld, st, f, a);
      e.isLoad = ld;
      e.data = (e.err || !ld) ? 32'h0 : modelLoad(f, a);
      size = 1 << f[1:0];
      have = 1'b0;
      cur = '0;
      if (!e.err) begin
        for (int k = 0; k < size; k++) begin
          ba = a + k;
          lane = ba[1:0];
          if (!have || cur.addr != {ba[31:2], 2'b00}) begin
            if (have) bq.push_back(cur);
            cur = '0;
            cur.addr = {ba[31:2], 2'b00};
            cur.we = st;
            have = 1'b1;
          end
          cur.be[lane] = 1'b1;
          cur.wdata[{lane, 3'b000} +: 8] = sd[k*8 +: 8];
        end
        if (have) bq.push_back(cur);
      end
      if (e.err) e.respCycle = cycleCount + 1;
      else if (ld) e.respCycle = cycleCount + 1 + bq.size() * (2 + gntDelayCfg + rvalidDelayCfg);
      else if (bq.size() == 1) e.respCycle = cycleCount + 2 + gntDelayCfg;
      else e.respCycle = -1;
      foreach (bq[i]) beatQ.push_back(bq[i]);
      expQ.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || !req_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL resp_timeout: got %0d outstanding, expected 0", expQ.size());
      expQ.delete();
    end
    checkOutput("beats_consumed", beatQ.size(), 0);
    beatQ.delete();
  endtask

  // Memory responder: grants after gntDelayCfg cycles, returns read data rvalidDelayCfg cycles after grant.
  logic        inBeat = 1'b0;
  logic        readPending = 1'b0;
  logic [31:0] readAddr = '0;
  int          gntWait = 0;
  int          rvalidWait = 0;
  beat_t       snap;
  beat_t       curBeat;
  beat_t       expBeat;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (readPending) begin
      if (rvalidWait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = readWord(readAddr);
        readPending = 1'b0;
      end else begin
        rvalidWait--;
      end
    end
    curBeat = {mem_addr, mem_be, mem_we, mem_wdata};
    if (!rst_n) begin
      mem_gnt = 1'b0;
      inBeat = 1'b0;
    end else if (mem_req) begin
      if (!inBeat) begin
        inBeat = 1'b1;
        snap = curBeat;
        gntWait = gntDelayCfg;
      end else begin
        testsRun++;
        if (curBeat !== snap) begin
          testsFailed++;
          $display("[TB] FAIL beat_stable: got 0x%0h, expected 0x%0h", curBeat, snap);
        end
      end
      if (gntWait == 0) begin
        mem_gnt = 1'b1;
        inBeat = 1'b0;
        beatLog.push_back(curBeat);
        if (beatQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_beat: got mem_req at 0x%08h, expected none", mem_addr);
        end else begin
          expBeat = beatQ.pop_front();
          checkOutput("beat_addr", mem_addr, expBeat.addr);
          checkOutput("beat_be", {28'd0, mem_be}, {28'd0, expBeat.be});
          checkOutput("beat_we", {31'd0, mem_we}, {31'd0, expBeat.we});
          if (expBeat.we) checkOutput("beat_wdata", mem_wdata & laneMask(expBeat.be), expBeat.wdata);
        end
        if (mem_we) begin
          for (int j = 0; j < 4; j++) if (mem_be[j]) memBytes[(mem_addr + j) & 1023] = mem_wdata[j*8 +: 8];
        end else begin
          readPending = 1'b1;
          readAddr = mem_addr;
          rvalidWait = rvalidDelayCfg;
        end
      end else begin
        mem_gnt = 1'b0;
        gntWait--;
      end
    end else begin
      mem_gnt = 1'b0;
    end
  end

  resp_t got;
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      respCount++;
      lastRespErr = resp_err;
      lastRespData = load_data;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_resp: got resp_valid 1, expected 0");
      end else begin
        got = expQ.pop_front();
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, got.err});
        if (got.err || got.isLoad) checkOutput("load_data", load_data, got.data);
        if (got.respCycle >= 0) checkOutput("resp_cycle", cycleCount, got.respCycle);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {27'd0, req_ready, resp_valid, resp_err, mem_req, mem_we}, 32'h0);
    checkOutput({tag, "_load_data"}, load_data, 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_be"}, {28'd0, mem_be}, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  int respBefore;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    fn3 = '0;
    addr = '0;
    store_data = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) memBytes[i] = 8'h00;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", {31'd0, req_ready}, 32'h0);
    @(negedge clk);
    checkOutput("ready_after_edge", {31'd0, req_ready}, 32'h1);

    // Aligned word load
    writeWord(32'h100, 32'h800000F1);
    beatLog.delete();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    waitIdle();
    checkOutput("tp1_data", lastRespData, 32'h800000F1);
    checkOutput("tp1_err", {31'd0, lastRespErr}, 32'h0);
    checkOutput("tp1_addr", getBeat(0).addr, 32'h100);
    checkOutput("tp1_be", {28'd0, getBeat(0).be}, 32'hF);

    // Byte loads, signed and unsigned, top lane
    writeWord(32'h100, 32'h80112233);
    beatLog.delete();
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    waitIdle();
    checkOutput("tp2_lb", lastRespData, 32'hFFFFFF80);
    checkOutput("tp2_be", {28'd0, getBeat(0).be}, 32'h8);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    waitIdle();
    checkOutput("tp2_lbu", lastRespData, 32'h00000080);

    // Halfword stores, immediate then delayed grant
    beatLog.delete();
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF);
    waitIdle();
    checkOutput("tp3_wdata", getBeat(0).wdata, 32'hBEEF0000);
    checkOutput("tp3_be", {28'd0, getBeat(0).be}, 32'hC);
    checkOutput("tp3_we", {31'd0, getBeat(0).we}, 32'h1);
    gntDelayCfg = 3;
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h100, 32'h5678CAFE);
    waitIdle();
    gntDelayCfg = 0;
    checkOutput("tp3_delayed_wdata", getBeat(1).wdata, 32'h5678CAFE);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    waitIdle();
    checkOutput("tp3_lh", lastRespData, 32'hFFFFBEEF);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h100, 32'h0);
    waitIdle();
    checkOutput("tp3_lhu", lastRespData, 32'h0000CAFE);
    beatLog.delete();
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);
    waitIdle();
    checkOutput("unaligned_lh", lastRespData, 32'hFFFFEFCA);
    checkOutput("unaligned_be", {28'd0, getBeat(0).be}, 32'h6);

    // Word-crossing load and store
    writeWord(32'h100, 32'h44332211);
    writeWord(32'h104, 32'h88776655);
    beatLog.delete();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h103, 32'h0);
    waitIdle();
`ifdef MISALIGNED_EN
    checkOutput("tp4_data", lastRespData, 32'h77665544);
    checkOutput("tp4_b0_addr", getBeat(0).addr, 32'h100);
    checkOutput("tp4_b0_be", {28'd0, getBeat(0).be}, 32'h8);
    checkOutput("tp4_b1_addr", getBeat(1).addr, 32'h104);
    checkOutput("tp4_b1_be", {28'd0, getBeat(1).be}, 32'h7);
`else
    checkOutput("tp4_err", {31'd0, lastRespErr}, 32'h1);
    checkOutput("tp4_no_beats", beatLog.size(), 0);
`endif
    beatLog.delete();
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0FE, 32'hAABBCCDD);
    waitIdle();
`ifdef MISALIGNED_EN
    checkOutput("tp5_b0_addr", getBeat(0).addr, 32'h0FC);
    checkOutput("tp5_b0_be", {28'd0, getBeat(0).be}, 32'hC);
    checkOutput("tp5_b0_wdata", getBeat(0).wdata, 32'hCCDD0000);
    checkOutput("tp5_b1_addr", getBeat(1).addr, 32'h100);
    checkOutput("tp5_b1_be", {28'd0, getBeat(1).be}, 32'h3);
    checkOutput("tp5_b1_wdata", getBeat(1).wdata, 32'h0000AABB);
`else
    checkOutput("tp5_err", {31'd0, lastRespErr}, 32'h1);
    checkOutput("tp5_no_beats", beatLog.size(), 0);
`endif

    // Rejected requests
    applyStimulus(1'b1, 1'b0, 3'b111, 32'h100, 32'h0);
    waitIdle();
    checkOutput("fn3_111_err", {31'd0, lastRespErr}, 32'h1);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h100, 32'h55);
    waitIdle();
    checkOutput("store_unsigned_err", {31'd0, lastRespErr}, 32'h1);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
    waitIdle();
    checkOutput("load_and_store_err", {31'd0, lastRespErr}, 32'h1);
    respBefore = respCount;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    repeat (4) @(negedge clk);
    checkOutput("no_op_ignored", respCount - respBefore, 0);

    // Reset during WAIT0; the late read data must not produce a response
    rvalidDelayCfg = 4;
    respBefore = respCount;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    expQ.delete();
    beatQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rst_mid_no_resp", respCount - respBefore, 0);
    rvalidDelayCfg = 0;
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    waitIdle();
    checkOutput("tp6_ld_err", {31'd0, lastRespErr}, 32'h1);
    checkOutput("tp6_ld_data", lastRespData, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
